// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero operands, divide by zero and signed overflow finish at acceptance.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]     counter_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   mcand_reg;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              divzero_reg;
    logic [XLEN-1:0]   result_reg;
    logic [4:0]        rd_out_reg;

    logic            accept;
    logic            in_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            last_iter;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] iter_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    logic            early_hit;
    logic [XLEN-1:0] early_result;

    // ---------------- operand decode at acceptance ----------------
    assign accept   = (state_reg != CALC) && bus.start;
    assign in_div   = bus.funct3[2];
    assign a_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                      (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    assign b_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) ||
                      (bus.funct3 == F_REM);
    assign a_neg    = a_signed && bus.op_a[XLEN-1];
    assign b_neg    = b_signed && bus.op_b[XLEN-1];
    assign a_abs    = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    assign b_abs    = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    assign last_iter = (counter_reg == LAST_ITER);

`ifdef MULDIV_EARLY_OUT_EN
    logic in_ovf;
    assign in_ovf = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                    (bus.op_a == INT_MIN) && (bus.op_b == {XLEN{1'b1}});

    always_comb begin
        early_hit    = (bus.op_a == '0) || (bus.op_b == '0) || in_ovf;
        early_result = '0;
        if (in_div && (bus.op_b == '0)) begin
            early_result = bus.funct3[1] ? bus.op_a : {XLEN{1'b1}};
        end else if (in_ovf) begin
            early_result = bus.funct3[1] ? '0 : INT_MIN;
        end
    end
`else
    assign early_hit    = 1'b0;
    assign early_result = '0;
`endif

    // ---------------- single-bit iteration ----------------
    // Multiply: multiplier sits in the low half and shifts out LSB first.
    // Divide: acc = {remainder, dividend}; dividend bits shift into the remainder MSB first.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
        div_trial = {1'b0, acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]} - {2'b00, mcand_reg};
        if (!div_trial[XLEN+1]) begin
            div_next = {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc_reg[2*XLEN-2:0], 1'b0};
        end
        iter_next = funct3_reg[2] ? div_next : mul_next;
    end

    // Sign correction and result select on the value produced by the last iteration.
    always_comb begin
        prod_fix = neg_q_reg ? (~iter_next + 1'b1) : iter_next;
        if (divzero_reg) begin
            quo_fix = {XLEN{1'b1}};
        end else begin
            quo_fix = neg_q_reg ? (~iter_next[XLEN-1:0] + 1'b1) : iter_next[XLEN-1:0];
        end
        rem_fix = neg_r_reg ? (~iter_next[2*XLEN-1:XLEN] + 1'b1) : iter_next[2*XLEN-1:XLEN];
        case (funct3_reg)
            F_MUL:         final_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:        final_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: final_result = quo_fix;
            default:       final_result = rem_fix;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CALC: begin
                if (bus.kill) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: begin
                if (bus.start) begin
                    state_next = early_hit ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy   = (state_reg == CALC);
        bus.done   = (state_reg == DONE);
        bus.result = result_reg;
        bus.rd_out = rd_out_reg;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_reg <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            funct3_reg  <= '0;
            rd_reg      <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            divzero_reg <= 1'b0;
            result_reg  <= '0;
            rd_out_reg  <= '0;
        end else if (accept) begin
            counter_reg <= '0;
            funct3_reg  <= bus.funct3;
            rd_reg      <= bus.rd_in;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            divzero_reg <= in_div && (bus.op_b == '0);
            if (in_div) begin
                acc_reg   <= {{XLEN{1'b0}}, a_abs};
                mcand_reg <= b_abs;
            end else begin
                acc_reg   <= {{XLEN{1'b0}}, b_abs};
                mcand_reg <= a_abs;
            end
            if (early_hit) begin
                result_reg <= early_result;
                rd_out_reg <= bus.rd_in;
            end
        end else if ((state_reg == CALC) && !bus.kill) begin
            acc_reg     <= iter_next;
            counter_reg <= counter_reg + 1'b1;
            if (last_iter) begin
                result_reg <= final_result;
                rd_out_reg <= rd_reg;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against a
// 64-bit arithmetic reference, kill, ignored start, back-to-back and asynchronous reset.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp = 32'h0;

    // Reference: plain 64-bit signed/unsigned arithmetic with RISC-V corner-case rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        p  = 64'h0;
        case (f)
            3'd0: p = {32'h0, a} * {32'h0, b};
            3'd1: p = 64'(sa * sb) >> 32;
            3'd2: p = 64'(sa * ub) >> 32;
            3'd3: p = ({32'h0, a} * {32'h0, b}) >> 32;
            3'd4: p = (b == 0) ? 64'hFFFFFFFF : 64'(sa / sb);
            3'd5: p = (b == 0) ? 64'hFFFFFFFF : {32'h0, a / b};
            3'd6: p = (b == 0) ? {32'h0, a} : 64'(sa % sb);
            default: p = (b == 0) ? {32'h0, a} : {32'h0, a % b};
        endcase
        return p[31:0];
    endfunction

    // Edges after the start edge until done is seen.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0 ||
            ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF))
            return 0;
`endif
        return XLEN;
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output logic pulse_ok);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = -1;
        res = bus.result;
        rdo = bus.rd_out;
        @(posedge clk);
        #1;
        pulse_ok = !bus.done;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        n_tests++; if (bus.rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  tf [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] ta [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] tb_ [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] te [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res;
        logic [4:0]  rdo, rd;
        int          lat, elat;
        logic        pok;
        for (int i = 0; i < 12; i++) begin
            rd   = (i == 0) ? 5'd5 : 5'(i + 10);
            elat = exp_lat(tf[i], ta[i], tb_[i]);
            do_op(tf[i], ta[i], tb_[i], rd, res, rdo, lat, pok);
            last_exp = te[i];
            $display("[TB] dir %0d f=%0d a=%h b=%h -> %h lat=%0d", i, tf[i], ta[i], tb_[i], res, lat);
            n_tests++; if (res !== te[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, res, te[i]); end
            n_tests++; if (rdo !== rd) begin n_fail++; $display("FAIL dir%0d_rd got %0d want %0d", i, rdo, rd); end
            n_tests++; if (lat != elat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
            n_tests++; if (pok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_pulse done still high, want single cycle", i); end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp, res;
        logic [4:0]  rd, rdo;
        int          lat, elat;
        logic        pok;
        for (int i = 0; i < 40; i++) begin
            f    = 3'($urandom);
            a    = pick_operand();
            b    = pick_operand();
            rd   = 5'($urandom);
            exp  = model(f, a, b);
            elat = exp_lat(f, a, b);
            do_op(f, a, b, rd, res, rdo, lat, pok);
            last_exp = exp;
            $display("[TB] rnd %0d f=%0d a=%h b=%h -> %h lat=%0d", i, f, a, b, res, lat);
            n_tests++; if (res !== exp) begin n_fail++; $display("FAIL rnd%0d_result got %h want %h", i, res, exp); end
            n_tests++; if (rdo !== rd) begin n_fail++; $display("FAIL rnd%0d_rd got %0d want %0d", i, rdo, rd); end
            n_tests++; if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_kill();
        logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd3; bus.op_a = 32'h12345678; bus.op_b = 32'h9ABCDEF1; bus.rd_in = 5'd21;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        $display("[TB] kill at iteration 10 busy=%b", bus.busy);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", bus.busy); end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL kill_no_done got done=1 want none"); end
        n_tests++; if (bus.result !== last_exp) begin n_fail++; $display("FAIL kill_result got %h want %h", bus.result, last_exp); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd7; bus.rd_in = 5'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); lat++; end
        #1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd2; bus.op_b = 32'd3; bus.rd_in = 5'd30;
        @(posedge clk);
        lat++;
        #1;
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        last_exp = 32'd142;
        $display("[TB] ignored-start result=%h rd=%0d lat=%0d", bus.result, bus.rd_out, lat);
        n_tests++; if (bus.result !== 32'd142) begin n_fail++; $display("FAIL ign_result got %h want %h", bus.result, 32'd142); end
        n_tests++; if (bus.rd_out !== 5'd3) begin n_fail++; $display("FAIL ign_rd got %0d want 3", bus.rd_out); end
        n_tests++; if (lat != XLEN) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", lat, XLEN); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp2;
        exp2 = model(3'd6, 32'hFFFF0001, 32'd12345);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd1; bus.op_a = 32'hDEADBEEF; bus.op_b = 32'h00C0FFEE; bus.rd_in = 5'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        bus.start = 1'b1; bus.funct3 = 3'd6; bus.op_a = 32'hFFFF0001; bus.op_b = 32'd12345; bus.rd_in = 5'd8;
        $display("[TB] b2b first result=%h lat=%0d", bus.result, lat);
        n_tests++; if (bus.result !== model(3'd1, 32'hDEADBEEF, 32'h00C0FFEE)) begin n_fail++;
            $display("FAIL b2b1_result got %h want %h", bus.result, model(3'd1, 32'hDEADBEEF, 32'h00C0FFEE)); end
        n_tests++; if (lat != XLEN) begin n_fail++; $display("FAIL b2b1_latency got %0d want %0d", lat, XLEN); end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_nobubble busy got %b want 1", bus.busy); end
        lat = 0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        last_exp = exp2;
        $display("[TB] b2b second result=%h rd=%0d lat=%0d", bus.result, bus.rd_out, lat);
        n_tests++; if (bus.result !== exp2) begin n_fail++; $display("FAIL b2b2_result got %h want %h", bus.result, exp2); end
        n_tests++; if (bus.rd_out !== 5'd8) begin n_fail++; $display("FAIL b2b2_rd got %0d want 8", bus.rd_out); end
        n_tests++; if (lat != XLEN) begin n_fail++; $display("FAIL b2b2_latency got %0d want %0d", lat, XLEN); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        pok;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'h1234; bus.op_b = 32'h55; bus.rd_in = 5'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] async reset busy=%b done=%b result=%h rd=%0d", bus.busy, bus.done, bus.result, bus.rd_out);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", bus.done); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL arst_result got %h want 0", bus.result); end
        n_tests++; if (bus.rd_out !== 5'h0) begin n_fail++; $display("FAIL arst_rd got %0d want 0", bus.rd_out); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        do_op(3'd0, 32'd3, 32'd4, 5'd9, res, rdo, lat, pok);
        $display("[TB] post-reset MUL 3x4 -> %h rd=%0d lat=%0d", res, rdo, lat);
        n_tests++; if (res !== 32'd12) begin n_fail++; $display("FAIL arst_mul_result got %h want %h", res, 32'd12); end
        n_tests++; if (rdo !== 5'd9) begin n_fail++; $display("FAIL arst_mul_rd got %0d want 9", rdo); end
        n_tests++; if (lat != XLEN) begin n_fail++; $display("FAIL arst_mul_latency got %0d want %0d", lat, XLEN); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
